// File: rtl/move_planner.sv
// move_planner: once per game step, plans the next cell of Pac-Man and the
// four ghosts, rejecting wall and board-edge moves by reading the board RAM,
// then hands the plan to the board writer and commits it on completion.
module move_planner #(
    parameter int         COLS         = 32,
    parameter int         ROWS         = 32,
    parameter logic [9:0] PAC_START    = 10'd0,
    parameter logic [9:0] INKY_START   = 10'd0,
    parameter logic [9:0] CLYDE_START  = 10'd0,
    parameter logic [9:0] PINKY_START  = 10'd0,
    parameter logic [9:0] BLINKY_START = 10'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] moveEn,
    input  logic [1:0] dirPac,
    input  logic [1:0] dirInky,
    input  logic [1:0] dirClyde,
    input  logic [1:0] dirPinky,
    input  logic [1:0] dirBlinky,
    output logic [9:0] readAddr,
    input  logic [3:0] readData,
    output logic [9:0] posPacman,
    output logic [9:0] posInky,
    output logic [9:0] posClyde,
    output logic [9:0] posPinky,
    output logic [9:0] posBlinky,
    output logic [9:0] posPacman_next,
    output logic [9:0] posInky_next,
    output logic [9:0] posClyde_next,
    output logic [9:0] posPinky_next,
    output logic [9:0] posBlinky_next,
    output logic       start,
    input  logic       finished,
    output logic       busy,
    output logic       ateFood,
    output logic       atePower,
    output logic       caught
);

    localparam int         COL_BITS  = $clog2(COLS);
    localparam bit         COLS_POW2 = (COLS == (1 << COL_BITS));
    localparam logic [9:0] COLS_W    = 10'(COLS);
    localparam logic [9:0] LAST_COL  = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW  = 10'(ROWS - 1);

    localparam logic [3:0] CODE_WALL  = 4'd1;
    localparam logic [3:0] CODE_FOOD  = 4'd2;
    localparam logic [3:0] CODE_POWER = 4'd8;

    typedef enum logic [2:0] {IDLE, REQ, CHK, START, WAIT, COMMIT} state_t;

    state_t     state;
    logic [9:0] pos     [5];
    logic [9:0] nxt     [5];
    logic [1:0] dir_q   [5];
    logic [4:0] en_q;
    logic [2:0] idx;
    logic       food_q;
    logic       power_q;
    logic [9:0] addr_q;

    logic [9:0] cur;
    logic [9:0] row;
    logic [9:0] col;
    logic [9:0] cand;
    logic       at_edge;
    logic       pac_hit;

    assign posPacman      = pos[0];
    assign posInky        = pos[1];
    assign posClyde       = pos[2];
    assign posPinky       = pos[3];
    assign posBlinky      = pos[4];
    assign posPacman_next = nxt[0];
    assign posInky_next   = nxt[1];
    assign posClyde_next  = nxt[2];
    assign posPinky_next  = nxt[3];
    assign posBlinky_next = nxt[4];

    // The candidate address is shown directly during REQ so the RAM returns
    // its data in CHK; outside REQ the last requested address is held.
    assign readAddr = (state == REQ) ? cand : addr_q;

    // Candidate cell of the entity being planned; left/right wrap within the row
    always_comb begin
        cur = pos[idx];
        if (COLS_POW2) begin
            row = cur >> COL_BITS;
            col = cur & LAST_COL;
        end else begin
            row = cur / COLS_W;
            col = cur % COLS_W;
        end
        at_edge = 1'b0;
        case (dir_q[idx])
            2'd0: begin
                at_edge = (row == '0);
                cand    = cur - COLS_W;
            end
            2'd1:    cand = (col == LAST_COL) ? cur - LAST_COL : cur + 10'd1;
            2'd2: begin
                at_edge = (row == LAST_ROW);
                cand    = cur + COLS_W;
            end
            default: cand = (col == '0) ? cur + LAST_COL : cur - 10'd1;
        endcase
    end

    // Collision: same next cell as a ghost, or Pac-Man and a ghost swap cells
    always_comb begin
        pac_hit = 1'b0;
        for (int unsigned g = 1; g < 5; g++) begin
            if (nxt[0] == nxt[g] || (nxt[0] == pos[g] && nxt[g] == pos[0]))
                pac_hit = 1'b1;
        end
    end

    // Planner FSM with registered handshake and event outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pos[0]   <= PAC_START;
            pos[1]   <= INKY_START;
            pos[2]   <= CLYDE_START;
            pos[3]   <= PINKY_START;
            pos[4]   <= BLINKY_START;
            nxt[0]   <= PAC_START;
            nxt[1]   <= INKY_START;
            nxt[2]   <= CLYDE_START;
            nxt[3]   <= PINKY_START;
            nxt[4]   <= BLINKY_START;
            for (int unsigned i = 0; i < 5; i++) dir_q[i] <= '0;
            en_q     <= '0;
            idx      <= '0;
            food_q   <= 1'b0;
            power_q  <= 1'b0;
            addr_q   <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            ateFood  <= 1'b0;
            atePower <= 1'b0;
            caught   <= 1'b0;
        end else begin
            start    <= 1'b0;
            ateFood  <= 1'b0;
            atePower <= 1'b0;
            caught   <= 1'b0;
            case (state)
                IDLE: begin
                    for (int unsigned i = 0; i < 5; i++) nxt[i] <= pos[i];
                    if (tick) begin
                        dir_q[0] <= dirPac;
                        dir_q[1] <= dirInky;
                        dir_q[2] <= dirClyde;
                        dir_q[3] <= dirPinky;
                        dir_q[4] <= dirBlinky;
                        en_q     <= moveEn;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    addr_q <= cand;
                    state  <= CHK;
                end
                CHK: begin
                    if (en_q[idx] && !at_edge && readData != CODE_WALL) begin
                        nxt[idx] <= cand;
                        if (idx == 3'd0) begin
                            if (readData == CODE_FOOD)  food_q  <= 1'b1;
                            if (readData == CODE_POWER) power_q <= 1'b1;
                        end
                    end
                    if (idx == 3'd4) begin
                        start <= 1'b1;
                        state <= START;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= REQ;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (finished) state <= COMMIT;
                end
                COMMIT: begin
                    for (int unsigned i = 0; i < 5; i++) pos[i] <= nxt[i];
                    ateFood  <= food_q;
                    atePower <= power_q;
                    caught   <= pac_hit;
                    food_q   <= 1'b0;
                    power_q  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/move_planner.md
Name: move_planner

Overview:
- Sits directly upstream of the board-writer stage; once per game step it computes the next cell of Pac-Man and the four ghosts.
- It reads the board RAM to reject moves into walls, then drives current/next positions and a one-cycle start pulse to the writer.
- It waits for the writer's finished pulse, then commits the next positions as current positions.
- It also reports food eaten, super-power pellet eaten, and Pac-Man/ghost collision.

Parameters:
- COLS, 32, board columns; address = row*COLS + col; COLS*ROWS <= 1024.
- ROWS, 32, board rows.
- PAC_START, 10'd0, reset cell of Pac-Man.
- INKY_START, 10'd0, reset cell of Inky.
- CLYDE_START, 10'd0, reset cell of Clyde.
- PINKY_START, 10'd0, reset cell of Pinky.
- BLINKY_START, 10'd0, reset cell of Blinky.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle game-step request.
- moveEn  in  5  per-entity move enable {blinky,pinky,clyde,inky,pac}; 0 = entity stays.
- dirPac, dirInky, dirClyde, dirPinky, dirBlinky  in  2 each  direction: 0 up, 1 right, 2 down, 3 left.
- readAddr  out  10  board RAM read address.
- readData  in  4  board object code; valid the cycle after readAddr is presented.
- posPacman, posInky, posClyde, posPinky, posBlinky  out  10 each  committed current cells.
- posPacman_next, posInky_next, posClyde_next, posPinky_next, posBlinky_next  out  10 each  planned next cells.
- start  out  1  one-cycle pulse to the writer.
- finished  in  1  writer completion pulse.
- busy  out  1  high from tick acceptance until commit.
- ateFood, atePower, caught  out  1 each  one-cycle pulses at commit.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - each pos* = its *_START; each pos*_next = its *_START.
  - readAddr=0, start=0, busy=0, ateFood=0, atePower=0, caught=0.
  - state = IDLE.
- Reset mid-operation aborts immediately to these values; no start or commit is issued afterwards.
- States: IDLE, REQ, CHK, START, WAIT, COMMIT. Entity index e steps in the order pac, inky, clyde, pinky, blinky.
- IDLE:
  - all pos*_next track pos*.
  - on tick: latch all dir* and moveEn, set e=pac, busy=1, go to REQ.
  - tick while busy is ignored; no queueing.
- Candidate computation (combinational from pos[e] and latched dir[e]):
  - row = pos/COLS, col = pos%COLS.
  - up: row-1; down: row+1.
  - right: col+1, wraps to 0 at COLS-1 (same row, tunnel).
  - left: col-1, wraps to COLS-1 at col 0.
  - up at row 0 or down at ROWS-1 is an edge block.
- REQ: readAddr = candidate; go to CHK.
- CHK (readData is valid this cycle):
  - next[e] = pos[e] if moveEn[e]=0, edge block, or readData==1 (wall); else next[e] = candidate.
  - codes 0 and 2-8 are passable for all entities.
  - for e=pac with a move accepted: readData==2 sets foodFlag; readData==8 sets powerFlag.
  - if e=blinky go to START, else e++ and go to REQ.
- Planning takes exactly 10 cycles after the tick cycle.
- START:
  - start=1 for exactly one cycle.
  - pos*/pos*_next are stable from here until COMMIT.
  - go to WAIT.
- WAIT:
  - hold all outputs; stay until finished=1. There is no timeout.
  - finished arriving in the same cycle as START is not accepted; it is only sampled in WAIT.
- COMMIT (one cycle):
  - pos* <= pos*_next.
  - ateFood = foodFlag; atePower = powerFlag; flags are cleared.
  - caught = 1 if posPacman_next equals any ghost next cell, or equals a ghost current cell while that ghost's next cell equals posPacman (swap).
  - busy=0 on the next cycle; return to IDLE.
  - a tick during COMMIT is ignored.
- readAddr holds its last value outside REQ.
- All address arithmetic is 10-bit unsigned.
- Division/modulo by COLS: power-of-two COLS must synthesise to shift/mask; other values use a counter-free combinational divide.

Test Plan:
- Reset released, no tick → all pos*=*_START, start never asserts, busy=0.
- PAC_START=33, dirPac=1, readData=0 for all reads, moveEn=5'b00001, tick:
  - start pulses exactly 11 cycles after the tick.
  - posPacman_next=34, ghost next cells unchanged.
  - after finished: posPacman=34.
- Pac-Man at col 31 row 1 (addr 63), dirPac=1 → readAddr=32, posPacman_next=32 (wrap).
  - Same setup with readData=1 → posPacman_next=63 and no ateFood.
- Pac-Man move into a cell returning code 2 → ateFood pulses once at commit.
  - Code 8 → atePower pulses once.
  - Blinky with dirBlinky=0 at row 0 → posBlinky_next=posBlinky.
- Pac-Man at 40 moving right, Inky at 41 moving left, all passable → both next cells swap, caught=1 at commit.
  - Second tick issued during WAIT is ignored (only one start pulse).
- Assert reset during WAIT → outputs return to *_START immediately, busy=0.
  - A later finished pulse causes no commit; the next tick restarts planning normally.
